// File: rtl/aqua_mem_ctrl_if.sv
// aqua_mem_ctrl_if: request/response bus between the core's arbiter (master)
// and the aqua_mem_ctrl on-chip memory (slave).
interface aqua_mem_ctrl_if #(
   parameter int MEM_DATA_WIDTH = 32,
   parameter int MEM_ADDR_WIDTH = 32
);
   logic [MEM_ADDR_WIDTH-1:0] memAddr;
   logic                      memWr;
   logic                      memReq;
   logic [MEM_DATA_WIDTH-1:0] memDataIn;
   logic                      memBusyOut;
   logic [MEM_DATA_WIDTH-1:0] memDataOut;
   logic                      memDone;
   logic                      memErr;

   modport master (
      output memAddr, memWr, memReq, memDataIn,
      input  memBusyOut, memDataOut, memDone, memErr
   );

   modport slave (
      input  memAddr, memWr, memReq, memDataIn,
      output memBusyOut, memDataOut, memDone, memErr
   );
endinterface

// File: rtl/aqua_mem_ctrl.sv
// aqua_mem_ctrl: single-port word memory with a fixed LATENCY-cycle busy window per access.
// Define AQUA_MEM_RANGE_CHECK_EN to flag and suppress accesses above DEPTH words.
module aqua_mem_ctrl #(
   parameter int MEM_DATA_WIDTH = 32,
   parameter int MEM_ADDR_WIDTH = 32,
   parameter int DEPTH          = 1024,
   parameter int LATENCY        = 2
) (
   input logic            clk,
   input logic            reset,
   aqua_mem_ctrl_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t                    state_r;
   state_t                    state_nx_s;
   logic [CNT_W-1:0]          wait_cnt_r;
   logic [MEM_ADDR_WIDTH-1:0] addr_r;
   logic                      wr_r;
   logic [MEM_DATA_WIDTH-1:0] wdata_r;
   logic [MEM_DATA_WIDTH-1:0] rdata_r;
   logic                      busy_r;
   logic                      done_r;
   logic                      err_r;
   logic [MEM_DATA_WIDTH-1:0] mem_r [DEPTH];

   logic [IDX_W-1:0]          idx_s;
   logic                      last_s;
   logic                      oor_s;
   logic                      capture_s;
   logic                      wr_en_s;
   logic                      rd_en_s;
   logic                      addr_unused_s;

   assign idx_s         = addr_r[2 +: IDX_W];
   assign last_s        = (state_r == WAIT) && (wait_cnt_r == CNT_ZERO);
   assign addr_unused_s = ^addr_r;

`ifdef AQUA_MEM_RANGE_CHECK_EN
   assign oor_s = ((addr_r >> (2 + IDX_W)) != {MEM_ADDR_WIDTH{1'b0}});
`else
   assign oor_s = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic: IDLE waits for a request, WAIT runs down the latency counter
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.memReq) begin
               state_nx_s = WAIT;
            end else begin
               state_nx_s = IDLE;
            end
         end
         WAIT: begin
            if (wait_cnt_r == CNT_ZERO) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = WAIT;
            end
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // Output/control decode: request capture in IDLE, access strobes on the last WAIT cycle
   always_comb begin
      capture_s = 1'b0;
      wr_en_s   = 1'b0;
      rd_en_s   = 1'b0;
      case (state_r)
         IDLE: begin
            capture_s = bus.memReq;
         end
         WAIT: begin
            wr_en_s = last_s & wr_r & ~oor_s;
            rd_en_s = last_s & ~wr_r;
         end
         default: begin
            capture_s = 1'b0;
         end
      endcase
   end

   // Request capture, wait counter and registered bus outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_r <= CNT_ZERO;
         addr_r     <= {MEM_ADDR_WIDTH{1'b0}};
         wr_r       <= 1'b0;
         wdata_r    <= {MEM_DATA_WIDTH{1'b0}};
         rdata_r    <= {MEM_DATA_WIDTH{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         busy_r <= (state_nx_s == WAIT);
         done_r <= last_s;
         err_r  <= last_s & oor_s;
         if (capture_s) begin
            addr_r     <= bus.memAddr;
            wr_r       <= bus.memWr;
            wdata_r    <= bus.memDataIn;
            wait_cnt_r <= CNT_LOAD;
         end else if ((state_r == WAIT) && (wait_cnt_r != CNT_ZERO)) begin
            wait_cnt_r <= wait_cnt_r - CNT_ONE;
         end
         if (rd_en_s) begin
            rdata_r <= oor_s ? {MEM_DATA_WIDTH{1'b0}} : mem_r[idx_s];
         end
      end
   end

   // Storage array: never cleared; a write coinciding with reset is abandoned
   always_ff @(posedge clk) begin
      if (wr_en_s && !reset) begin
         mem_r[idx_s] <= wdata_r;
      end
   end

   assign bus.memBusyOut = busy_r;
   assign bus.memDataOut = rdata_r;
   assign bus.memDone    = done_r;
   assign bus.memErr     = err_r;
endmodule
